// File: rtl/core_ex_fwd_stage.sv
// core_ex_fwd_stage
//   Execute-stage operand forwarding followed by a 2-entry elastic EX/MEM
//   buffer. Each source operand is resolved against NFWD forwarding sources
//   (index 0 is the youngest). If the matching source still has a load
//   pending, the instruction stalls. Resolved operands and an opaque payload
//   are queued, and the head entry is presented downstream.
//
// Ports
//   clk, rest          clock (rising edge), async active-high reset
//   flush              drop buffered and same-cycle incoming instructions
//   in_*               upstream valid/ready, register indices/values, payload
//   fwd_*              per-source rd / write / data_valid / data (slice j)
//   out_*              head entry valid/ready, resolved operands, payload
//   hazard_stall       in_valid && load-use hazard

// Resolves one source operand against the forwarding sources.
module core_ex_fwd_resolve #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int NFWD = 2
) (
    input  logic [REGW-1:0]      rs,
    input  logic                 rs_valid,
    input  logic [XLEN-1:0]      rs_value,
    input  logic [NFWD*REGW-1:0] fwd_rd,
    input  logic [NFWD-1:0]      fwd_write,
    input  logic [NFWD-1:0]      fwd_data_valid,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]      value,
    output logic                 hazard
);
    logic found;

    // Scanning upward while holding the first hit gives younger-first
    // priority. An older match cannot override a younger one, even when the
    // younger one is still waiting on a load.
    always_comb begin
        value  = rs_value;
        hazard = 1'b0;
        found  = 1'b0;
        for (int j = 0; j < NFWD; j++) begin
            if (!found && rs_valid && (rs != '0) && fwd_write[j] &&
                (fwd_rd[j*REGW +: REGW] == rs)) begin
                found = 1'b1;
                if (fwd_data_valid[j]) value  = fwd_data[j*XLEN +: XLEN];
                else                   hazard = 1'b1;
            end
        end
    end
endmodule

module core_ex_fwd_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int NFWD = 2,
    parameter int PW   = 48
) (
    input  logic                 clk,
    input  logic                 rest,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REGW-1:0]      in_rs1,
    input  logic [REGW-1:0]      in_rs2,
    input  logic                 in_rs1_valid,
    input  logic                 in_rs2_valid,
    input  logic [XLEN-1:0]      in_rs1_value,
    input  logic [XLEN-1:0]      in_rs2_value,
    input  logic [PW-1:0]        in_payload,
    input  logic [NFWD*REGW-1:0] fwd_rd,
    input  logic [NFWD-1:0]      fwd_write,
    input  logic [NFWD-1:0]      fwd_data_valid,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_rs1_value,
    output logic [XLEN-1:0]      out_rs2_value,
    output logic [PW-1:0]        out_payload,
    output logic                 hazard_stall
);
    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [PW-1:0]   payload;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t          state, state_nx;
    entry_t          mem [2];
    logic            head, tail;
    logic [XLEN-1:0] rs1_res, rs2_res;
    logic            hz1, hz2, hazard;
    logic            accept, pop;

    core_ex_fwd_resolve #(.XLEN(XLEN), .REGW(REGW), .NFWD(NFWD)) u_rs1 (
        .rs(in_rs1), .rs_valid(in_rs1_valid), .rs_value(in_rs1_value),
        .fwd_rd(fwd_rd), .fwd_write(fwd_write), .fwd_data_valid(fwd_data_valid),
        .fwd_data(fwd_data), .value(rs1_res), .hazard(hz1)
    );

    core_ex_fwd_resolve #(.XLEN(XLEN), .REGW(REGW), .NFWD(NFWD)) u_rs2 (
        .rs(in_rs2), .rs_valid(in_rs2_valid), .rs_value(in_rs2_value),
        .fwd_rd(fwd_rd), .fwd_write(fwd_write), .fwd_data_valid(fwd_data_valid),
        .fwd_data(fwd_data), .value(rs2_res), .hazard(hz2)
    );

    // in_ready depends only on local occupancy and the hazard. It has no
    // combinational path from out_ready, so a full buffer refuses input even
    // in a cycle where it is being drained.
    assign hazard       = hz1 | hz2;
    assign in_ready     = (state != FULL) && !hazard;
    assign hazard_stall = in_valid && hazard;
    assign accept       = in_valid && in_ready;
    assign out_valid    = (state != EMPTY);
    assign pop          = out_valid && out_ready;

    assign out_rs1_value = mem[head].rs1;
    assign out_rs2_value = mem[head].rs2;
    assign out_payload   = mem[head].payload;

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (accept) state_nx = ONE;
                ONE:     if (accept && !pop) state_nx = FULL;
                         else if (!accept && pop) state_nx = EMPTY;
                FULL:    if (pop) state_nx = ONE;
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state  <= EMPTY;
            head   <= 1'b0;
            tail   <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            state <= state_nx;
            if (flush) begin
                head <= 1'b0;
                tail <= 1'b0;
            end else begin
                if (accept) begin
                    mem[tail] <= '{rs1: rs1_res, rs2: rs2_res, payload: in_payload};
                    tail      <= ~tail;
                end
                if (pop) head <= ~head;
            end
        end
    end
endmodule

// File: tb/tb_core_ex_fwd_stage.sv
// Directed bench for core_ex_fwd_stage. It covers forwarding priority,
// load-use stall, x0, buffer fill/drain, flush and asynchronous reset.
module tb_core_ex_fwd_stage;
    localparam int XLEN = 32, REGW = 5, NFWD = 2, PW = 48;

    logic                 clk = 1'b0;
    logic                 rest = 1'b1;
    logic                 flush = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [REGW-1:0]      in_rs1 = '0, in_rs2 = '0;
    logic                 in_rs1_valid = 1'b0, in_rs2_valid = 1'b0;
    logic [XLEN-1:0]      in_rs1_value = '0, in_rs2_value = '0;
    logic [PW-1:0]        in_payload = '0;
    logic [NFWD*REGW-1:0] fwd_rd = '0;
    logic [NFWD-1:0]      fwd_write = '0, fwd_data_valid = '0;
    logic [NFWD*XLEN-1:0] fwd_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [XLEN-1:0]      out_rs1_value, out_rs2_value;
    logic [PW-1:0]        out_payload;
    logic                 hazard_stall;

    int vectors = 0;
    int miscompares = 0;

    core_ex_fwd_stage #(.XLEN(XLEN), .REGW(REGW), .NFWD(NFWD), .PW(PW)) dut (
        .clk(clk), .rest(rest), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_valid(in_rs1_valid), .in_rs2_valid(in_rs2_valid),
        .in_rs1_value(in_rs1_value), .in_rs2_value(in_rs2_value),
        .in_payload(in_payload),
        .fwd_rd(fwd_rd), .fwd_write(fwd_write),
        .fwd_data_valid(fwd_data_valid), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value),
        .out_payload(out_payload), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle 1ns so checks sit away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic [47:0] p);
        in_valid = 1'b1; in_rs1 = r1; in_rs2 = r2;
        in_rs1_valid = 1'b1; in_rs2_valid = 1'b1;
        in_rs1_value = v1; in_rs2_value = v2; in_payload = p;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_rs1", 64'(out_rs1_value), 64'd0);
        chk("rst_out_rs2", 64'(out_rs2_value), 64'd0);
        chk("rst_payload", 64'(out_payload), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rest = 1'b0;
        step();

        // Plain pass-through, no forwarding matches
        instr(5'd3, 5'd4, 32'h11, 32'h22, 48'hCAFE_0001);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        step(); in_valid = 1'b0;
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_rs1", 64'(out_rs1_value), 64'h11);
        chk("t1_rs2", 64'(out_rs2_value), 64'h22);
        chk("t1_payload", 64'(out_payload), 64'hCAFE_0001);
        step();
        chk("t1_drained", 64'(out_valid), 64'd0);

        // Two sources hit rs1: the youngest one must win
        fwd_rd = {5'd5, 5'd5}; fwd_write = 2'b11; fwd_data_valid = 2'b11;
        fwd_data = {32'hBBBB, 32'hAAAA};
        instr(5'd5, 5'd4, 32'h99, 32'h22, 48'h2);
        step(); in_valid = 1'b0;
        chk("t2_youngest", 64'(out_rs1_value), 64'hAAAA);
        chk("t2_rs2_nofwd", 64'(out_rs2_value), 64'h22);
        step();
        // Only the older source writes, so it supplies rs1
        fwd_write = 2'b10;
        instr(5'd5, 5'd4, 32'h99, 32'h22, 48'h3);
        step(); in_valid = 1'b0;
        chk("t2_older", 64'(out_rs1_value), 64'hBBBB);
        step();

        // Load-use hazard on rs2
        fwd_rd = {5'd0, 5'd7}; fwd_write = 2'b01; fwd_data_valid = 2'b00;
        fwd_data = {32'h0, 32'h1234};
        instr(5'd3, 5'd7, 32'h11, 32'h77, 48'h4);
        #1;
        chk("t3_in_ready", 64'(in_ready), 64'd0);
        chk("t3_hazard_stall", 64'(hazard_stall), 64'd1);
        in_valid = 1'b0; #1;
        chk("t3_stall_needs_valid", 64'(hazard_stall), 64'd0);
        chk("t3_ready_indep_valid", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        step();
        chk("t3_not_accepted", 64'(out_valid), 64'd0);
        fwd_data_valid = 2'b01; #1;
        chk("t3_ready_resolved", 64'(in_ready), 64'd1);
        step(); in_valid = 1'b0;
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        chk("t3_rs2_fwd", 64'(out_rs2_value), 64'h1234);
        step();

        // x0 is never forwarded and never stalls
        fwd_rd = {5'd0, 5'd0}; fwd_write = 2'b01; fwd_data_valid = 2'b00;
        fwd_data = {32'h0, 32'hDEAD};
        instr(5'd0, 5'd4, 32'h0, 32'h22, 48'h5);
        #1;
        chk("t4_x0_ready", 64'(in_ready), 64'd1);
        chk("t4_x0_nostall", 64'(hazard_stall), 64'd0);
        step(); in_valid = 1'b0;
        chk("t4_x0_value", 64'(out_rs1_value), 64'd0);
        step();
        fwd_write = 2'b00;

        // Fill the buffer while downstream is stalled, then drain in order
        out_ready = 1'b0;
        instr(5'd1, 5'd2, 32'hA1, 32'hA2, 48'hA);
        step();
        instr(5'd1, 5'd2, 32'hB1, 32'hB2, 48'hB);
        step();
        chk("t5_full_ready", 64'(in_ready), 64'd0);
        chk("t5_head_a", 64'(out_rs1_value), 64'hA1);
        step(); in_valid = 1'b0;
        chk("t5_head_hold", 64'(out_payload), 64'hA);
        out_ready = 1'b1;
        step();
        chk("t5_pop2_valid", 64'(out_valid), 64'd1);
        chk("t5_head_b", 64'(out_rs2_value), 64'hB2);
        step();
        chk("t5_empty", 64'(out_valid), 64'd0);
        chk("t5_ready_back", 64'(in_ready), 64'd1);

        // Simultaneous accept and pop keep occupancy at one
        instr(5'd1, 5'd2, 32'hC1, 32'hC2, 48'hC);
        step();
        instr(5'd1, 5'd2, 32'hD1, 32'hD2, 48'hD);
        step(); in_valid = 1'b0;
        chk("t5_stream_head", 64'(out_payload), 64'hD);
        step();
        chk("t5_stream_empty", 64'(out_valid), 64'd0);

        // Flush with a full buffer
        out_ready = 1'b0;
        instr(5'd1, 5'd2, 32'hE1, 32'hE2, 48'hE);
        step(); step();
        flush = 1'b1; #1;
        step(); flush = 1'b0; in_valid = 1'b0;
        chk("t6_flush_full", 64'(out_valid), 64'd0);
        // Flush with one entry and an incoming instruction that would be accepted
        instr(5'd1, 5'd2, 32'hF1, 32'hF2, 48'hF);
        step();
        flush = 1'b1; #1;
        chk("t6_flush_ready", 64'(in_ready), 64'd1);
        step(); flush = 1'b0; in_valid = 1'b0;
        chk("t6_flush_one", 64'(out_valid), 64'd0);
        step();
        chk("t6_dropped", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        instr(5'd1, 5'd2, 32'h51, 32'h52, 48'h50);
        step(); in_valid = 1'b0;
        #2 rest = 1'b1; #1;
        chk("t7_rst_valid", 64'(out_valid), 64'd0);
        chk("t7_rst_rs1", 64'(out_rs1_value), 64'd0);
        step(); rest = 1'b0; out_ready = 1'b1;
        step();
        chk("t7_after_release", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/core_ex_fwd_stage.md
Name: core_ex_fwd_stage

Overview:
- Parametrised execute-stage operand forwarding network combined with a 2-entry elastic EX/MEM output buffer.
- Resolves rs1/rs2 against NFWD younger-first forwarding sources.
- Stalls on load-use hazards (matching source whose data is not yet valid).
- Registers forwarded operands plus an opaque payload, with valid/ready on both sides and a pipeline flush.
- Sits between the ID/EX register and the ALU/MEM stage; successor to the fixed 3-source, single-register EX stage.

Parameters:
- XLEN, 32, operand/data width.
- REGW, 5, register index width.
- NFWD, 2, number of forwarding sources; index 0 = youngest (EX/MEM), higher = older.
- PW, 48, width of opaque payload carried alongside operands.

Ports:
- clk  input  1  clock, rising edge.
- rest  input  1  reset, asynchronous, active-high.
- flush  input  1  discard all buffered and incoming instructions.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage accepts this cycle.
- in_rs1  input  REGW  source register 1 index.
- in_rs2  input  REGW  source register 2 index.
- in_rs1_valid  input  1  rs1 is read by the instruction.
- in_rs2_valid  input  1  rs2 is read by the instruction.
- in_rs1_value  input  XLEN  register-file value for rs1.
- in_rs2_value  input  XLEN  register-file value for rs2.
- in_payload  input  PW  opaque side data (rd, ops, pc...).
- fwd_rd  input  NFWD*REGW  destination index per source; slice j = [j*REGW +: REGW].
- fwd_write  input  NFWD  source j writes a register.
- fwd_data_valid  input  NFWD  source j data available (0 = load pending).
- fwd_data  input  NFWD*XLEN  forwarded data per source.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes head.
- out_rs1_value  output  XLEN  resolved rs1 of head.
- out_rs2_value  output  XLEN  resolved rs2 of head.
- out_payload  output  PW  payload of head.
- hazard_stall  output  1  in_valid && hazard (for perf counters/debug).

Behaviour:
- Forward select, per operand rsX:
  - Skip if in_rsX_valid=0 or in_rsX=0.
  - Otherwise pick the lowest j with fwd_write[j] && fwd_rd[j]==in_rsX.
  - If the match has fwd_data_valid[j]=1, the value is fwd_data[j]; if it has fwd_data_valid[j]=0, assert hazard.
  - No match: use in_rsX_value.
  - Register x0 always resolves to in_rsX_value, never forwarded and never a hazard.
- in_ready = (count!=2) && !hazard.
  - hazard is computed from indices regardless of in_valid.
  - in_ready never depends combinationally on out_ready.
- Accept = in_valid && in_ready. Resolved operands and payload are written into the buffer.
- Buffer: 2-entry FIFO (head/tail pointer, count 0..2).
  - States EMPTY (count 0), ONE (count 1), FULL (count 2).
  - Pop = out_valid && out_ready.
  - Accept only: count+1. Pop only: count-1. Both: count unchanged, pointers advance.
  - FULL + accept is impossible (in_ready=0).
- Latency: accept in cycle N gives out_valid in cycle N+1 with the resolved values. Throughput is 1/cycle while out_ready=1.
- Outputs are driven from the head entry and are stable while out_valid && !out_ready.
- hazard_stall = in_valid && hazard.
- flush (synchronous, sampled at the edge):
  - count returns to 0 next cycle and out_valid=0.
  - Any same-cycle accept is dropped; flush wins over accept and pop.
  - in_ready is unaffected in the flush cycle itself.
- Reset (rest=1, async):
  - count=0, pointers=0, out_valid=0.
  - out_rs1_value, out_rs2_value and out_payload read 0 (entries cleared).
  - Mid-operation reset discards all entries immediately; no partial output is presented after release.
- Multiple matches: the youngest (lowest j) wins even if an older match has valid data.
- Hazard on one operand stalls the whole instruction even if the other resolves.

Test Plan:
- Reset, then in_valid=1, rs1=3, rs2=4, no fwd matches, in values 0x11/0x22 -> next cycle out_valid=1, out_rs1=0x11, out_rs2=0x22, payload echoed.
- fwd_rd[0]=5 and fwd_rd[1]=5, both writing, data 0xAAAA/0xBBBB, rs1=5 -> out_rs1=0xAAAA (youngest wins).
- Load-use: fwd_rd[0]=7, write=1, data_valid=0, rs2=7 -> in_ready=0, hazard_stall=1. Raise data_valid with data 0x1234 -> accepted, out_rs2=0x1234.
- rs1=0 with fwd_rd[0]=0, write=1, data 0xDEAD, in_rs1_value=0 -> out_rs1=0, no hazard.
- out_ready=0, push 2 instructions -> count 2, in_ready=0, head held. out_ready=1 for 2 cycles -> both drained in order, in_ready back to 1.
- Buffer FULL, then flush with in_valid=1 -> next cycle out_valid=0, count 0, incoming instruction not delivered. Assert rest mid-stream -> out_valid=0 immediately.
